// File: rtl/approx_mult_pipe.sv
// Pipelined W x W unsigned multiplier with per-beat exact/approximate mode and valid/ready flow.
// Optional error statistic (err_max, stat_clr) is built when APPROX_ERR_STAT_EN is defined.
module approx_mult_pipe #(
  parameter int unsigned W    = 8,
  parameter int unsigned K    = W,
  parameter int unsigned COMP = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_a,
  input  logic [W-1:0]    in_b,
  input  logic            in_exact,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*W-1:0]  out_p,
  output logic            out_exact
`ifdef APPROX_ERR_STAT_EN
  ,
  input  logic            stat_clr,
  output logic [2*W-1:0]  err_max
`endif
);

  localparam int unsigned PW      = 2 * W;
  localparam int          Ki      = int'(K);
  localparam logic [PW-1:0] LowMask = (PW'(1) << K) - PW'(1);
  localparam logic [PW-1:0] CompVal = PW'(COMP) & LowMask;

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // S1: partial-product rows, with columns below K dropped in approx mode
  logic [W-1:0] pp_d [W];
  logic         or_lo_d, or_hi_d;

  always_comb begin
    or_lo_d = 1'b0;
    or_hi_d = 1'b0;
    for (int j = 0; j < int'(W); j++) begin
      pp_d[j] = in_a & {W{in_b[j]}};
      for (int i = 0; i < int'(W); i++) begin
        if (!in_exact && (i + j < Ki)) begin
          if (i + j == Ki - 1) begin
            if (j < Ki / 2) or_lo_d = or_lo_d | pp_d[j][i];
            else            or_hi_d = or_hi_d | pp_d[j][i];
          end
          pp_d[j][i] = 1'b0;
        end
      end
    end
  end

  logic         s1_v, s1_lo, s1_hi, s1_ex;
  logic [W-1:0] s1_pp [W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v  <= 1'b0;
      s1_lo <= 1'b0;
      s1_hi <= 1'b0;
      s1_ex <= 1'b0;
      for (int j = 0; j < int'(W); j++) s1_pp[j] <= '0;
    end else if (adv) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_lo <= or_lo_d;
        s1_hi <= or_hi_d;
        s1_ex <= in_exact;
        for (int j = 0; j < int'(W); j++) s1_pp[j] <= pp_d[j];
      end
    end
  end

  // S2: reduce the rows to two operands (even rows / odd rows) plus the column-(K-1) carry
  logic [PW-1:0] sa_d, sb_d;
  logic [1:0]    e_d;

  always_comb begin
    sa_d = '0;
    sb_d = '0;
    for (int j = 0; j < int'(W); j++) begin
      if (j % 2 == 0) sa_d = sa_d + (PW'(s1_pp[j]) << j);
      else            sb_d = sb_d + (PW'(s1_pp[j]) << j);
    end
    e_d = {1'b0, s1_lo} + {1'b0, s1_hi};
  end

  logic          s2_v, s2_ex;
  logic [PW-1:0] s2_sa, s2_sb;
  logic [1:0]    s2_e;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v  <= 1'b0;
      s2_ex <= 1'b0;
      s2_sa <= '0;
      s2_sb <= '0;
      s2_e  <= '0;
    end else if (adv) begin
      s2_v  <= s1_v;
      s2_ex <= s1_ex;
      s2_sa <= sa_d;
      s2_sb <= sb_d;
      s2_e  <= e_d;
    end
  end

  // S3: carry-propagate add; approx results carry the compensation constant in the low K bits
  logic [PW-1:0] p_d;

  always_comb begin
    p_d = s2_sa + s2_sb + (PW'(s2_e) << K);
    if (!s2_ex) p_d = (p_d & ~LowMask) | CompVal;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_p     <= '0;
      out_exact <= 1'b0;
    end else if (adv) begin
      out_valid <= s2_v;
      out_p     <= p_d;
      out_exact <= s2_ex;
    end
  end

`ifdef APPROX_ERR_STAT_EN
  logic [W-1:0]  s1_a, s1_b, s2_a, s2_b;
  logic [PW-1:0] ex_p, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_a <= '0;
      s1_b <= '0;
      s2_a <= '0;
      s2_b <= '0;
      ex_p <= '0;
    end else if (adv) begin
      if (in_valid) begin
        s1_a <= in_a;
        s1_b <= in_b;
      end
      s2_a <= s1_a;
      s2_b <= s1_b;
      ex_p <= PW'(s2_a) * PW'(s2_b);
    end
  end

  assign err_d = (ex_p >= out_p) ? (ex_p - out_p) : (out_p - ex_p);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_max <= '0;
    end else if (stat_clr) begin
      err_max <= '0;
    end else if (out_valid && out_ready && !out_exact && (err_d > err_max)) begin
      err_max <= err_d;
    end
  end
`endif

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Self-checking bench for approx_mult_pipe (W=8, K=8, COMP=6): fixed vectors, stall, reset
// and randomized traffic scored against an arithmetic reference model.
module tb_approx_mult_pipe;

  localparam int unsigned W    = 8;
  localparam int unsigned K    = 8;
  localparam int unsigned COMP = 6;
  localparam int unsigned PW   = 2 * W;

  logic          clk, rst_n;
  logic          in_valid, in_ready, in_exact;
  logic [W-1:0]  in_a, in_b;
  logic          out_valid, out_ready, out_exact;
  logic [PW-1:0] out_p;

  approx_mult_pipe #(.W(W), .K(K), .COMP(COMP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_exact  (in_exact),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .out_exact (out_exact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec  = 0;
  int nfail = 0;

  logic [PW:0] sbq [$];
  logic        hold_pending = 1'b0;
  logic [PW:0] held;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: sum the surviving partial products, add the two column-(K-1) ORs, wrap, append COMP.
  function automatic logic [PW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic ex);
    longint unsigned h;
    int              e_lo, e_hi;
    longint unsigned r;
    if (ex) return PW'(a) * PW'(b);
    h    = 0;
    e_lo = 0;
    e_hi = 0;
    for (int i = 0; i < int'(W); i++) begin
      for (int j = 0; j < int'(W); j++) begin
        if (a[i] && b[j]) begin
          if (i + j >= int'(K)) h += longint'(1) << (i + j);
          if (i + j == int'(K) - 1) begin
            if (j < int'(K) / 2) e_lo = 1;
            else                 e_hi = 1;
          end
        end
      end
    end
    r = ((h >> K) + longint'(e_lo) + longint'(e_hi)) % (longint'(1) << (PW - K));
    return PW'((r << K) | (longint'(COMP) & ((longint'(1) << K) - 1)));
  endfunction

  // One clock: drive, score handshakes at the negedge, then move past the rising edge.
  task automatic step(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic ex, input logic ordy);
    logic [PW:0] exp;
    in_valid  = iv;
    in_a      = a;
    in_b      = b;
    in_exact  = ex;
    out_ready = ordy;
    @(negedge clk);
    if (hold_pending) chk("hold stable", {15'd0, out_valid, out_exact, out_p}, {15'd0, 1'b1, held});
    hold_pending = out_valid && !out_ready;
    held         = {out_exact, out_p};
    if (out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        chk("spurious out_valid", {31'd0, out_valid}, 32'd0);
      end else begin
        exp = sbq.pop_front();
        chk("scoreboard", {15'd0, out_exact, out_p}, {15'd0, exp});
      end
    end
    if (in_valid && in_ready) sbq.push_back({ex, model(a, b, ex)});
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          ex;
    logic [PW-1:0] p;
  } vec_t;

  vec_t tbl [8];
  int   lat;
  int   guard;

  initial begin
    tbl[0] = '{8'hFF, 8'hFF, 1'b0, 16'hF906};
    tbl[1] = '{8'hFF, 8'hFF, 1'b1, 16'hFE01};
    tbl[2] = '{8'h80, 8'h01, 1'b0, 16'h0106};
    tbl[3] = '{8'h00, 8'hA5, 1'b0, 16'h0006};
    tbl[4] = '{8'h01, 8'h80, 1'b0, 16'h0106};
    tbl[5] = '{8'h0F, 8'h0F, 1'b0, 16'h0006};
    tbl[6] = '{8'h81, 8'h81, 1'b0, 16'h4206};
    tbl[7] = '{8'h81, 8'h81, 1'b1, 16'h4101};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_exact  = 1'b0;
    out_ready = 1'b0;
    #12;
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset out_p", {16'd0, out_p}, 32'd0);
    chk("reset out_exact", {31'd0, out_exact}, 32'd0);
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single beats: check latency and value
    for (int v = 0; v < 8; v++) begin
      in_valid  = 1'b1;
      in_a      = tbl[v].a;
      in_b      = tbl[v].b;
      in_exact  = tbl[v].ex;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat      = 1;
      while (!out_valid && lat < 8) begin
        @(posedge clk);
        #1;
        lat++;
      end
      chk("table latency", 32'(lat), 32'd3);
      chk("table product", {15'd0, out_exact, out_p}, {15'd0, tbl[v].ex, tbl[v].p});
      @(posedge clk);
      #1;
    end

    // Back-to-back stream at full rate: 10 beats must all retire after 13 clocks
    for (int n = 0; n < 10; n++)
      step(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'b1);
    for (int n = 0; n < 3; n++) step(1'b0, '0, '0, 1'b0, 1'b1);
    chk("stream drained", 32'(sbq.size()), 32'd0);
    chk("stream out_valid idle", {31'd0, out_valid}, 32'd0);

    // Three beats in flight, consumer stalls 5 cycles
    for (int n = 0; n < 3; n++)
      step(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'b0);
    for (int n = 0; n < 5; n++) begin
      chk("stall in_ready", {31'd0, in_ready}, 32'd0);
      step(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0);
    end
    for (int n = 0; n < 3; n++) step(1'b0, '0, '0, 1'b0, 1'b1);
    chk("stall drained", 32'(sbq.size()), 32'd0);

    // Reset with two beats in flight
    step(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0);
    step(1'b1, 8'h81, 8'h81, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    chk("pre-reset out_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("async reset out_p", {16'd0, out_p}, 32'd0);
    sbq.delete();
    hold_pending = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int n = 0; n < 6; n++) step(1'b0, '0, '0, 1'b0, 1'b1);

    // Random traffic with random back-pressure
    for (int n = 0; n < 400; n++)
      step(1'($urandom_range(0, 3) != 0), W'($urandom), W'($urandom), 1'($urandom),
           1'($urandom_range(0, 2) != 0));
    guard = 0;
    while (sbq.size() != 0 && guard < 50) begin
      step(1'b0, '0, '0, 1'b0, 1'b1);
      guard++;
    end
    chk("random drained", 32'(sbq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
